// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: stimulus and measurement signals of one divider monitor.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             div_in;
    logic [CNT_W:0]   expected_ratio;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             locked;
    logic             ratio_err;
    logic             stuck;

    modport master (
        output enable, div_in, expected_ratio,
        input  high_len, low_len, period, meas_valid, locked, ratio_err, stuck
    );

    modport slave (
        input  enable, div_in, expected_ratio,
        output high_len, low_len, period, meas_valid, locked, ratio_err, stuck
    );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high/low phase and period of a divided clock, tracks lock to an expected ratio and flags a stuck input.
module clk_div_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input logic              clk,
    input logic              rst_n,
    clk_div_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [3:0]       LOCK = 4'(LOCK_CNT);

    state_t           state, state_next;
    logic             s1, s2, s3, rise, fall, latch, stuck_set;
    logic [CNT_W-1:0] wcnt, hcnt, lcnt, act_cnt, wcnt_next, hcnt_next, lcnt_next;
    logic [CNT_W:0]   sum;
    logic [3:0]       mcnt, mcnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX) ? v : v + 1'b1;
    endfunction

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    assign sum  = {1'b0, hcnt} + {1'b0, lcnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        act_cnt    = '0;
        latch      = 1'b0;
        case (state)
            IDLE:      state_next = WAIT_RISE;
            WAIT_RISE: begin
                act_cnt = wcnt;
                if (rise) state_next = MEAS_HIGH;
            end
            MEAS_HIGH: begin
                act_cnt = hcnt;
                if (fall) state_next = MEAS_LOW;
            end
            default: begin
                act_cnt = lcnt;
                if (rise) begin
                    state_next = MEAS_HIGH;
                    latch      = 1'b1;
                end
            end
        endcase
        if (!bus.enable) begin
            state_next = IDLE;
            latch      = 1'b0;
        end
        // Fires on the cycle the active counter saturates with no edge present
        stuck_set = bus.enable && state != IDLE && !(rise || fall) && act_cnt >= MAX - 1'b1;
    end

    always_comb begin
        wcnt_next = (state == WAIT_RISE && !rise) ? sat_inc(wcnt) : '0;
        hcnt_next = (state == IDLE) ? '0
                  : (rise && state != MEAS_HIGH) ? CNT_W'(1)
                  : (state == MEAS_HIGH && !fall) ? sat_inc(hcnt) : hcnt;
        lcnt_next = (state == IDLE) ? '0
                  : (fall && state == MEAS_HIGH) ? CNT_W'(1)
                  : (state == MEAS_LOW && !rise) ? sat_inc(lcnt) : lcnt;
        mcnt_next = !bus.meas_valid ? mcnt
                  : (bus.period != bus.expected_ratio) ? '0
                  : (mcnt == LOCK) ? mcnt : mcnt + 1'b1;
        if (!bus.enable) begin
            wcnt_next = '0;
            hcnt_next = '0;
            lcnt_next = '0;
        end
        if (!bus.enable || stuck_set)
            mcnt_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1             <= 1'b0;
            s2             <= 1'b0;
            s3             <= 1'b0;
            wcnt           <= '0;
            hcnt           <= '0;
            lcnt           <= '0;
            mcnt           <= '0;
            bus.high_len   <= '0;
            bus.low_len    <= '0;
            bus.period     <= '0;
            bus.meas_valid <= 1'b0;
            bus.locked     <= 1'b0;
            bus.ratio_err  <= 1'b0;
            bus.stuck      <= 1'b0;
        end else begin
            s1             <= bus.div_in;
            s2             <= s1;
            s3             <= s2;
            wcnt           <= wcnt_next;
            hcnt           <= hcnt_next;
            lcnt           <= lcnt_next;
            mcnt           <= mcnt_next;
            bus.locked     <= mcnt_next == LOCK;
            bus.meas_valid <= latch;
            bus.ratio_err  <= latch && sum != bus.expected_ratio;
            bus.stuck      <= bus.enable && !(rise || fall) && (stuck_set || bus.stuck);
            if (latch) begin
                bus.high_len <= hcnt;
                bus.low_len  <= lcnt;
                bus.period   <= sum;
            end
        end
    end
endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Receive-side checker for the FSM clock dividers. It samples a divided clock, which is asynchronous to `clk` or derived from it, through a 2-flop synchronizer. It measures the high-phase length, low-phase length and period in `clk` cycles, and asserts `locked` once the measured period matches `expected_ratio` for `LOCK_CNT` consecutive periods. It sits beside each divider instance in the clocking subsystem and gives bring-up and built-in self-test visibility of divider health: ratio, duty cycle and stuck output.

## Interface
- `CNT_W`, default 8: width of the phase counters. Saturation value is 2^CNT_W-1.
- `LOCK_CNT`, default 4: number of consecutive matching periods required to assert `locked`. Legal range is 1 to 15.
- `clk`, input, 1: measurement clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `enable`, input, 1: measurement enable. Level-sensitive.
- `div_in`, input, 1: divided clock under test. Asynchronous.
- `expected_ratio`, input, CNT_W+1: expected period in `clk` cycles. Quasi-static.
- `high_len`, output, CNT_W: last measured high-phase length.
- `low_len`, output, CNT_W: last measured low-phase length.
- `period`, output, CNT_W+1: last measured period, equal to `high_len` + `low_len`.
- `meas_valid`, output, 1: 1-cycle pulse when a new measurement is latched.
- `locked`, output, 1: period stable and equal to `expected_ratio`.
- `ratio_err`, output, 1: 1-cycle pulse when a measured period differs from `expected_ratio`.
- `stuck`, output, 1: no edge seen for 2^CNT_W-1 cycles.

## Operation
- **Synchronizer and edge detect.**
  - `div_in` passes through flops s1 and s2; s3 holds the previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- **State machine.** States are IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW. Reset state is IDLE.
- **IDLE:**
  - Counters are held at 0.
  - Go to WAIT_RISE when `enable`=1.
- **WAIT_RISE:**
  - The wait counter increments, saturating.
  - On rise: `hcnt`=1, go to MEAS_HIGH. The first partial period is discarded.
- **MEAS_HIGH:**
  - Each cycle without fall: `hcnt`++, saturating.
  - On fall: `lcnt`=1, go to MEAS_LOW.
- **MEAS_LOW:**
  - Each cycle without rise: `lcnt`++, saturating.
  - On rise, in the same cycle:
    - latch `high_len`=`hcnt`, `low_len`=`lcnt`, `period`=`hcnt`+`lcnt` (CNT_W+1 bits, no overflow);
    - pulse `meas_valid`;
    - set `hcnt`=1 and go to MEAS_HIGH.
- **Lock logic** (updates only with `meas_valid`):
  - If `period`==`expected_ratio`, the match counter increments, saturating at `LOCK_CNT`. `locked`=1 when the match counter equals `LOCK_CNT`.
  - On mismatch: pulse `ratio_err`, clear the match counter, set `locked`=0.
- **Stuck detection:**
  - `stuck` is set when the active counter reaches 2^CNT_W-1. The active counter is the wait counter in WAIT_RISE, `hcnt` in MEAS_HIGH, and `lcnt` in MEAS_LOW.
  - Setting `stuck` clears `locked` and the match counter.
  - The state machine keeps waiting for the next edge.
  - `stuck` clears on the next rise or fall edge.
  - A saturated phase still produces a measurement at the following rise. Its period is 2^CNT_W-1 plus the other phase, which is normally a mismatch.
- **Enable deassert in any state:**
  - Go to IDLE on the next cycle.
  - Clear counters, the match counter, `locked` and `stuck`.
  - `high_len`, `low_len` and `period` keep their last values.
  - No `meas_valid` or `ratio_err` pulse is issued.
- **Simultaneous events:** a mismatch and a stuck condition in the same cycle both take effect, so `locked`=0, `ratio_err` pulses and `stuck`=1.

## Timing
- **Reset values:** all outputs 0; state IDLE; s1, s2 and s3 = 0.
- **Input latency:**
  - A `div_in` edge is reflected in s2 after 2 `clk` cycles.
  - rise and fall are registered into the state machine in the cycle in which they are detected.
- **Output timing:**
  - `meas_valid` and `ratio_err` are high for exactly 1 cycle, coincident with the new `period` value.
  - `locked` rises 1 cycle after the `LOCK_CNT`-th matching `meas_valid`.
- **Measurement rate and resolution:**
  - Measurement resolution is ±1 cycle per phase for `div_in` asynchronous to `clk`.
  - Any input transition is accepted, including phases of 1 cycle.
  - One measurement is produced per `div_in` period after the first full period.

## Test plan
- **Divide-by-4, expected 4.** `div_in` from a divide-by-4 (2 high / 2 low) of `clk`, `expected_ratio`=4, `enable`=1 → `high_len`=2, `low_len`=2, `period`=4, `meas_valid` every 4 cycles, `locked`=1 after the 4th `meas_valid`, no `ratio_err`.
- **Divide-by-3, odd duty.** `div_in` 1 high / 2 low, `expected_ratio`=3 → `high_len`=1, `low_len`=2, `period`=3, `locked` after 4 periods.
- **Ratio mismatch.** Divide-by-4 input with `expected_ratio`=6 → `ratio_err` pulses on every `meas_valid`; `locked` stays 0.
- **Stuck input.** Lock on divide-by-4, then hold `div_in` low for 300 cycles → `stuck`=1 once `lcnt` reaches 255, `locked`=0. Resume toggling → `stuck` clears at the first rise; `locked` returns after 4 good periods. The first post-resume `meas_valid` reports `low_len`=255 and pulses `ratio_err`.
- **Enable drop.** Deassert `enable` for 1 cycle while locked → `locked`=0 next cycle, `period` holds 4, no pulses. The first `meas_valid` comes after the first complete period following re-enable.
- **Reset mid-period.** Assert `rst_n`=0 asynchronously during MEAS_LOW → all outputs 0 immediately. After release, measurement restarts from WAIT_RISE.
